serial_flash_loader: RTL and testbench

Boot-time controller that sequences the serial receive path into flash programming. It arms on a start pulse and parses a 2-byte big-endian length header (in 16-bit words) from the UART byte stream. It then assembles each following byte pair into a 16-bit word, high byte first, and issues one flash write per word via a req/ack handshake at consecutive addresses from a base. A small word FIFO absorbs the mismatch between UART byte rate and flash program time.

---
 rtl/serial_flash_loader_pkg.sv | 20 ++
 rtl/serial_flash_loader_if.sv | 19 +
 rtl/serial_flash_loader_word_fifo.sv | 57 +++++
 rtl/serial_flash_loader.sv | 125 ++++++++++++
 tb/tb_serial_flash_loader.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_flash_loader_pkg.sv
// Shared definitions for the serial flash loader.
// Contents: receive FSM state encoding, flash word width and
// length-header byte count.
package serial_flash_loader_pkg;

  localparam int WORD_W    = 16;
  localparam int HDR_BYTES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/serial_flash_loader_if.sv
// Flash write handshake bundle.
// Signals: req (write request, held until ack), addr (word address),
// data (word data), ack (one-cycle write-complete pulse).
// Modports: master drives req/addr/data, slave drives ack.
interface serial_flash_loader_if
  import serial_flash_loader_pkg::*;
#(
  parameter int ADDR_W = 22
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data;
  logic              ack;

  modport master (output req, output addr, output data, input ack);
  modport slave  (input req, input addr, input data, output ack);

endinterface

// File: rtl/serial_flash_loader_word_fifo.sv
// loader_word_fifo: synchronous word FIFO between the UART byte assembler
// and the flash write side.
// Ports: clk, rst (sync, active high), flush (empties FIFO), push/push_data,
// pop, head (word at read pointer), full, empty.
// A push while full is accepted when a pop happens in the same cycle.
module loader_word_fifo
  import serial_flash_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/serial_flash_loader.sv
// Boot-time loader: parses a 2-byte big-endian word count from the UART
// byte stream, assembles byte pairs into words (high byte first) and
// writes them to flash at consecutive addresses from base_addr.
// Ports: clk, rst (sync, active high), start, base_addr, rx_valid, rx_data,
// flash (write handshake master), busy, done, err_overrun, words_written.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_HDR_HI  | expecting length high byte
// S_HDR_LO  | expecting length low byte
// S_DATA_HI | expecting word high byte
// S_DATA_LO | expecting word low byte, push word
// S_DRAIN   | all words received, waiting for writes to finish
// S_DONE    | load complete
// S_ERROR   | FIFO overrun, finishing outstanding write only
module serial_flash_loader
  import serial_flash_loader_pkg::*;
#(
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  serial_flash_loader_if.master flash,
  output logic                 busy,
  output logic                 done,
  output logic                 err_overrun,
  output logic [15:0]          words_written
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_reg;
  logic [15:0]       len;
  logic [15:0]       rx_count;
  logic [15:0]       words_cnt;
  logic [7:0]        hi_byte;
  logic [WORD_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty;
  logic              start_ok, push, issue, overrun, flush;

  assign busy = (state inside {S_HDR_HI, S_HDR_LO, S_DATA_HI, S_DATA_LO, S_DRAIN})
             || (state == S_ERROR && flash.req);
  assign done          = (state == S_DONE);
  assign err_overrun   = (state == S_ERROR);
  assign words_written = words_cnt;

  assign start_ok = start && !busy;
  assign push     = (state == S_DATA_LO) && rx_valid;
  // The head word is popped as it is loaded into the write register, so the
  // outstanding write does not occupy a FIFO slot.
  assign issue    = !flash.req && !fifo_empty && (state != S_ERROR);
  assign overrun  = push && fifo_full && !issue;
  assign flush    = start_ok || (state == S_ERROR);

  loader_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({hi_byte, rx_data}),
    .pop       (issue),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start_ok) state_next = S_HDR_HI;
      S_HDR_HI:  if (rx_valid) state_next = S_HDR_LO;
      S_HDR_LO:  if (rx_valid) state_next = ({len[15:8], rx_data} == 16'd0) ? S_DONE : S_DATA_HI;
      S_DATA_HI: if (rx_valid) state_next = S_DATA_LO;
      S_DATA_LO: begin
        if (rx_valid) begin
          if (overrun)                     state_next = S_ERROR;
          else if (rx_count + 16'd1 == len) state_next = S_DRAIN;
          else                             state_next = S_DATA_HI;
        end
      end
      // Finishing on the final ack lets done/busy move one cycle after it.
      S_DRAIN:   if (fifo_empty && (!flash.req || flash.ack)) state_next = S_DONE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      base_reg   <= '0;
      len        <= '0;
      rx_count   <= '0;
      words_cnt  <= '0;
      hi_byte    <= '0;
      flash.req  <= 1'b0;
      flash.addr <= '0;
      flash.data <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        base_reg  <= base_addr;
        len       <= '0;
        rx_count  <= '0;
        words_cnt <= '0;
      end
      if (state == S_HDR_HI && rx_valid)  len[15:8] <= rx_data;
      if (state == S_HDR_LO && rx_valid)  len[7:0]  <= rx_data;
      if (state == S_DATA_HI && rx_valid) hi_byte   <= rx_data;
      if (push && !overrun) rx_count <= rx_count + 16'd1;
      if (issue) begin
        flash.req  <= 1'b1;
        flash.addr <= base_reg + ADDR_W'(words_cnt);
        flash.data <= fifo_head;
      end else if (flash.req && flash.ack) begin
        flash.req <= 1'b0;
        words_cnt <= words_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_flash_loader.sv
module tb_serial_flash_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [21:0] base_addr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        busy, done, err_overrun;
  logic [15:0] words_written;

  int checks = 0;
  int errors = 0;

  serial_flash_loader_if #(.ADDR_W(22)) flash_if ();

  serial_flash_loader #(.ADDR_W(22), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .base_addr     (base_addr),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .flash         (flash_if),
    .busy          (busy),
    .done          (done),
    .err_overrun   (err_overrun),
    .words_written (words_written)
  );

  always #5 clk = ~clk;

  // flash slave model and write log
  int          cyc = 0;
  bit          ack_en = 0;
  int          ack_delay = 3;
  int          req_cycles = 0;
  int          req_count = 0;
  int          wr_n = 0;
  int          ack_edge = 0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  bit          ack_sent = 0;
  logic        prev_req = 1'b0;
  logic [21:0] cap_addr;
  logic [15:0] cap_data;
  logic [21:0] wr_addr [16];
  logic [15:0] wr_data [16];

  always @(posedge clk) cyc++;

  initial begin
    flash_if.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_sent && flash_if.req === 1'b1) gap_viol++;
      ack_sent = 0;
      flash_if.ack = 1'b0;
      if (flash_if.req === 1'b1 && prev_req !== 1'b1) begin
        req_count++;
        cap_addr = flash_if.addr;
        cap_data = flash_if.data;
      end
      prev_req = flash_if.req;
      if (rst || !ack_en || flash_if.req !== 1'b1) begin
        req_cycles = 0;
      end else begin
        req_cycles++;
        if (flash_if.addr !== cap_addr || flash_if.data !== cap_data) stab_viol++;
        if (req_cycles == ack_delay) begin
          flash_if.ack = 1'b1;
          ack_sent = 1;
          if (wr_n < 16) begin
            wr_addr[wr_n] = flash_if.addr;
            wr_data[wr_n] = flash_if.data;
          end
          wr_n++;
          ack_edge = cyc + 1;
          req_cycles = 0;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_start(input logic [21:0] b);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_n = 0;
    req_count = 0;
    gap_viol = 0;
    stab_viol = 0;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s: done not seen within 200 cycles", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (flash_if.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", flash_if.req); end
    checks++; if (flash_if.addr !== 22'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", flash_if.addr); end
    checks++; if (flash_if.data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", flash_if.data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_overrun); end
    checks++; if (words_written !== 16'h0) begin errors++; $display("FAIL reset_words: got %h expected 0", words_written); end
    clear_log();
    ack_en = 1;
    send_byte(8'h12);
    send_byte(8'h34);
    repeat (10) @(negedge clk);
    checks++; if (req_count !== 0) begin errors++; $display("FAIL idle_no_req: got %0d requests expected 0", req_count); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || err_overrun !== 1'b0 || words_written !== 16'h0) begin
      errors++; $display("FAIL idle_outputs: busy=%b done=%b err=%b words=%h expected all 0", busy, done, err_overrun, words_written);
    end
  endtask

  task automatic test_basic();
    bit ok;
    clear_log();
    ack_en = 1; ack_delay = 3;
    do_start(22'h000100);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", busy); end
    send_byte(8'h00); send_byte(8'h02);
    send_word(16'hABCD); send_word(16'h1234);
    wait_done("basic_done", ok);
    if (ok) begin
      checks++; if (cyc !== ack_edge) begin errors++; $display("FAIL done_timing: done at edge %0d expected %0d", cyc, ack_edge); end
    end
    checks++; if (wr_n !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d expected 2", wr_n); end
    checks++; if (wr_addr[0] !== 22'h100 || wr_data[0] !== 16'hABCD) begin
      errors++; $display("FAIL basic_w0: got %h/%h expected 000100/abcd", wr_addr[0], wr_data[0]);
    end
    checks++; if (wr_addr[1] !== 22'h101 || wr_data[1] !== 16'h1234) begin
      errors++; $display("FAIL basic_w1: got %h/%h expected 000101/1234", wr_addr[1], wr_data[1]);
    end
    checks++; if (words_written !== 16'd2) begin errors++; $display("FAIL basic_words: got %0d expected 2", words_written); end
    checks++; if (busy !== 1'b0 || err_overrun !== 1'b0) begin errors++; $display("FAIL basic_flags: busy=%b err=%b expected 0 0", busy, err_overrun); end
  endtask

  task automatic test_zero_len();
    clear_log();
    do_start(22'h000020);
    send_byte(8'h00);
    send_byte(8'h00);
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: done=%b busy=%b expected 1 0", done, busy); end
    repeat (5) @(negedge clk);
    checks++; if (req_count !== 0 || words_written !== 16'h0) begin
      errors++; $display("FAIL zero_no_req: reqs=%0d words=%0d expected 0 0", req_count, words_written);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [15:0] w;
    clear_log();
    ack_en = 1; ack_delay = 6;
    do_start(22'h001000);
    send_byte(8'h00); send_byte(8'h05);
    for (int i = 0; i < 5; i++) begin
      w = 16'hC000 + 16'(i * 16'h0101);
      send_word(w);
    end
    wait_done("b2b_done", ok);
    checks++; if (wr_n !== 5 || err_overrun !== 1'b0) begin errors++; $display("FAIL b2b_count: writes=%0d err=%b expected 5 0", wr_n, err_overrun); end
    for (int i = 0; i < 5; i++) begin
      w = 16'hC000 + 16'(i * 16'h0101);
      checks++;
      if (wr_addr[i] !== 22'h001000 + 22'(i) || wr_data[i] !== w) begin
        errors++; $display("FAIL b2b_w%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i], 22'h001000 + 22'(i), w);
      end
    end
    checks++; if (gap_viol !== 0 || stab_viol !== 0) begin errors++; $display("FAIL b2b_protocol: gap=%0d stable=%0d expected 0 0", gap_viol, stab_viol); end
  endtask

  task automatic test_overrun();
    bit ok;
    clear_log();
    ack_en = 0; ack_delay = 1;
    do_start(22'h000200);
    send_byte(8'h00); send_byte(8'h06);
    send_word(16'h0102); send_word(16'h0304); send_word(16'h0506);
    send_word(16'h0708); send_word(16'h090A);
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b expected 0 after 5 words", err_overrun); end
    send_word(16'h0B0C);
    checks++; if (err_overrun !== 1'b1 || busy !== 1'b1 || flash_if.req !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: err=%b busy=%b req=%b expected 1 1 1", err_overrun, busy, flash_if.req);
    end
    ack_en = 1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin ok = 1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL ovr_busy: busy still %b after 20 cycles expected 0", busy); end
    repeat (10) @(negedge clk);
    checks++; if (words_written !== 16'd1 || req_count !== 1) begin
      errors++; $display("FAIL ovr_words: words=%0d reqs=%0d expected 1 1", words_written, req_count);
    end
    checks++; if (wr_addr[0] !== 22'h200 || wr_data[0] !== 16'h0102) begin
      errors++; $display("FAIL ovr_w0: got %h/%h expected 000200/0102", wr_addr[0], wr_data[0]);
    end
    checks++; if (err_overrun !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL ovr_sticky: err=%b done=%b expected 1 0", err_overrun, done); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_log();
    ack_en = 1; ack_delay = 2;
    do_start(22'h3FFFFF);
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL wrap_err_clear: got %b expected 0", err_overrun); end
    send_byte(8'h00); send_byte(8'h02);
    send_word(16'hDEAD); send_word(16'hBEEF);
    wait_done("wrap_done", ok);
    checks++; if (wr_addr[0] !== 22'h3FFFFF || wr_data[0] !== 16'hDEAD) begin
      errors++; $display("FAIL wrap_w0: got %h/%h expected 3fffff/dead", wr_addr[0], wr_data[0]);
    end
    checks++; if (wr_addr[1] !== 22'h000000 || wr_data[1] !== 16'hBEEF) begin
      errors++; $display("FAIL wrap_w1: got %h/%h expected 000000/beef", wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    ack_en = 0;
    do_start(22'h000040);
    send_byte(8'h00); send_byte(8'h03);
    send_word(16'h1111);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (flash_if.req === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_req: req=%b after 10 cycles expected 1", flash_if.req); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (flash_if.req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset: req=%b busy=%b expected 0 0", flash_if.req, busy);
    end
    rst = 1'b0;
    clear_log();
    ack_en = 1; ack_delay = 3;
    do_start(22'h000050);
    send_byte(8'h00); send_byte(8'h01);
    send_word(16'h5A5A);
    wait_done("mid_done", ok);
    checks++; if (wr_n !== 1 || wr_addr[0] !== 22'h50 || wr_data[0] !== 16'h5A5A) begin
      errors++; $display("FAIL mid_write: n=%0d got %h/%h expected 1 000050/5a5a", wr_n, wr_addr[0], wr_data[0]);
    end
    checks++; if (words_written !== 16'd1 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_words: words=%0d busy=%b expected 1 0", words_written, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_back_to_back();
    test_overrun();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
